// File: rtl/multi_digit_bcd_hex_counter_pkg.sv
// rtl/multi_digit_bcd_hex_counter_pkg.sv - shared encodings and digit helpers for the BCD/HEX counter
package multi_digit_bcd_hex_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] HEX_MAX = 4'd15;

    typedef enum logic {
        MODE_HEX = 1'b0,
        MODE_BCD = 1'b1
    } count_mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    // Largest legal digit value for the selected counting mode.
    function automatic logic [DIGIT_W-1:0] digit_max(input logic mode);
        return (mode == MODE_BCD) ? BCD_MAX : HEX_MAX;
    endfunction

    // Loaded digits above 9 are pinned to 9 in BCD; HEX takes the raw nibble.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] digit,
                                                       input logic mode);
        if ((mode == MODE_BCD) && (digit > BCD_MAX)) begin
            return BCD_MAX;
        end
        return digit;
    endfunction

endpackage

// File: rtl/counter_digit_cell.sv
// rtl/counter_digit_cell.sv - combinational next-value and carry/borrow for one counter digit
module counter_digit_cell
    import multi_digit_bcd_hex_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               mode,
    input  logic               direction,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] next_digit,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] max_value;

    assign max_value = digit_max(mode);

    // A digit left above max by a mode switch is normalised on any step
    // regardless of carry_in: up goes to 0 with carry, down goes to max
    // without borrow. Otherwise the digit only moves when carry_in is set.
    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (direction == DIR_UP) begin
            if (digit > max_value) begin
                next_digit = '0;
                carry_out  = 1'b1;
            end else if (carry_in) begin
                if (digit == max_value) begin
                    next_digit = '0;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end
        end else begin
            if (digit > max_value) begin
                next_digit = max_value;
            end else if (carry_in) begin
                if (digit == '0) begin
                    next_digit = max_value;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_digit_bcd_hex_counter.sv
// rtl/multi_digit_bcd_hex_counter.sv - N-digit BCD/HEX up/down counter with load, wrap pulse and limit flag
module multi_digit_bcd_hex_counter
    import multi_digit_bcd_hex_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                          clk_divider,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          mode,
    input  logic                          direction,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_count,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          carry_out,
    output logic                          at_limit
);

    localparam int CW = DIGIT_W * NUM_DIGITS;

    logic [CW-1:0]         next_count;
    logic [CW-1:0]         load_value;
    logic [NUM_DIGITS:0]   ripple;
    logic [NUM_DIGITS-1:0] digit_at_limit;
    logic                  wrap_event;

    // Digit 0 always steps; each higher digit steps on the carry/borrow of the one below.
    assign ripple[0] = 1'b1;

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            counter_digit_cell u_cell (
                .digit      (count[DIGIT_W*k +: DIGIT_W]),
                .mode       (mode),
                .direction  (direction),
                .carry_in   (ripple[k]),
                .next_digit (next_count[DIGIT_W*k +: DIGIT_W]),
                .carry_out  (ripple[k+1])
            );

            assign load_value[DIGIT_W*k +: DIGIT_W] =
                clamp_digit(load_count[DIGIT_W*k +: DIGIT_W], mode);

            assign digit_at_limit[k] = (direction == DIR_UP)
                ? (count[DIGIT_W*k +: DIGIT_W] == digit_max(mode))
                : (count[DIGIT_W*k +: DIGIT_W] == '0);
        end
    endgenerate

    assign at_limit = &digit_at_limit;

    // A full wrap is a step taken from the limit; the top digit then always emits a carry/borrow.
    assign wrap_event = at_limit & ripple[NUM_DIGITS];

    // Count register: reset beats load beats enable; saturating builds hold at the limit.
    always_ff @(posedge clk_divider) begin
        if (rst) begin
            count     <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            count     <= load_value;
            carry_out <= 1'b0;
        end else if (en) begin
            if (wrap_event && !WRAP_EN) begin
                carry_out <= 1'b0;
            end else begin
                count     <= next_count;
                carry_out <= wrap_event && WRAP_EN;
            end
        end else begin
            carry_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_digit_bcd_hex_counter.sv
// tb/tb_multi_digit_bcd_hex_counter.sv - scoreboard bench for wrapping and saturating counter builds
module tb_multi_digit_bcd_hex_counter;

    localparam int ND = 4;
    localparam int CW = 4 * ND;

    typedef struct {
        int            idx;
        logic [CW-1:0] cnt_w;
        logic          cy_w;
        logic          lim_w;
        logic [CW-1:0] cnt_s;
        logic          cy_s;
        logic          lim_s;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic          direction;
    logic          load;
    logic [CW-1:0] load_count;

    logic [CW-1:0] count_w;
    logic          carry_w;
    logic          limit_w;
    logic [CW-1:0] count_s;
    logic          carry_s;
    logic          limit_s;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   vec_no;

    multi_digit_bcd_hex_counter #(.NUM_DIGITS(ND), .WRAP_EN(1'b1)) dut_wrap (
        .clk_divider (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .direction   (direction),
        .load        (load),
        .load_count  (load_count),
        .count       (count_w),
        .carry_out   (carry_w),
        .at_limit    (limit_w)
    );

    multi_digit_bcd_hex_counter #(.NUM_DIGITS(ND), .WRAP_EN(1'b0)) dut_sat (
        .clk_divider (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .direction   (direction),
        .load        (load),
        .load_count  (load_count),
        .count       (count_s),
        .carry_out   (carry_s),
        .at_limit    (limit_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, want);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge and queue what both builds must show after the next rising edge.
    task automatic vec(input logic r, input logic ld, input logic e, input logic m, input logic d,
                       input logic [CW-1:0] lc,
                       input logic [CW-1:0] cw, input logic yw, input logic lw,
                       input logic [CW-1:0] cs, input logic ys, input logic ls);
        exp_t x;
        @(negedge clk);
        #1;
        rst        = r;
        load       = ld;
        en         = e;
        mode       = m;
        direction  = d;
        load_count = lc;
        x.idx   = vec_no;
        x.cnt_w = cw;
        x.cy_w  = yw;
        x.lim_w = lw;
        x.cnt_s = cs;
        x.cy_s  = ys;
        x.lim_s = ls;
        exp_q.push_back(x);
        vec_no++;
    endtask

    // Monitor: results are visible from the rising edge onward, sampled at the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("count_wrap", x.idx, 32'(count_w), 32'(x.cnt_w));
                chk("carry_wrap", x.idx, 32'(carry_w), 32'(x.cy_w));
                chk("limit_wrap", x.idx, 32'(limit_w), 32'(x.lim_w));
                chk("count_sat",  x.idx, 32'(count_s), 32'(x.cnt_s));
                chk("carry_sat",  x.idx, 32'(carry_s), 32'(x.cy_s));
                chk("limit_sat",  x.idx, 32'(limit_s), 32'(x.lim_s));
            end
        end
    end

    initial begin
        total = 0; bad = 0; vec_no = 0;
        rst = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b1; direction = 1'b1; load_count = '0;

        //  rst ld en md dr load_cnt   wrap: cnt  cy lim    sat: cnt  cy lim
        vec(1, 0, 0, 1, 1, 16'h0000,  16'h0000, 0, 0,  16'h0000, 0, 0);
        // BCD ripple across three digits
        vec(0, 1, 0, 1, 1, 16'h0999,  16'h0999, 0, 0,  16'h0999, 0, 0);
        vec(0, 0, 1, 1, 1, 16'h0000,  16'h1000, 0, 0,  16'h1000, 0, 0);
        // BCD full wrap up, pulse for one cycle only
        vec(0, 1, 0, 1, 1, 16'h9999,  16'h9999, 0, 1,  16'h9999, 0, 1);
        vec(0, 0, 1, 1, 1, 16'h0000,  16'h0000, 1, 0,  16'h9999, 0, 1);
        vec(0, 0, 1, 1, 1, 16'h0000,  16'h0001, 0, 0,  16'h9999, 0, 1);
        vec(0, 0, 0, 1, 1, 16'h0000,  16'h0001, 0, 0,  16'h9999, 0, 1);
        // HEX full wrap down
        vec(0, 1, 0, 0, 0, 16'h0000,  16'h0000, 0, 1,  16'h0000, 0, 1);
        vec(0, 0, 1, 0, 0, 16'h0000,  16'hFFFF, 1, 0,  16'h0000, 0, 1);
        vec(0, 0, 1, 0, 0, 16'h0000,  16'hFFFE, 0, 0,  16'h0000, 0, 1);
        // BCD load clamp then down step
        vec(0, 1, 0, 1, 0, 16'h3C7F,  16'h3979, 0, 0,  16'h3979, 0, 0);
        vec(0, 0, 1, 1, 0, 16'h0000,  16'h3978, 0, 0,  16'h3978, 0, 0);
        // HEX value with digit above 9, then BCD up step
        vec(0, 1, 0, 0, 1, 16'h00A5,  16'h00A5, 0, 0,  16'h00A5, 0, 0);
        vec(0, 0, 1, 1, 1, 16'h0000,  16'h0106, 0, 0,  16'h0106, 0, 0);
        // priority: reset over load/en, load over en
        vec(0, 1, 0, 0, 1, 16'h1234,  16'h1234, 0, 0,  16'h1234, 0, 0);
        vec(1, 1, 1, 0, 1, 16'h5555,  16'h0000, 0, 0,  16'h0000, 0, 0);
        vec(0, 1, 1, 0, 1, 16'h1234,  16'h1234, 0, 0,  16'h1234, 0, 0);
        // HEX full wrap up
        vec(0, 1, 0, 0, 1, 16'hFFFF,  16'hFFFF, 0, 1,  16'hFFFF, 0, 1);
        vec(0, 0, 1, 0, 1, 16'h0000,  16'h0000, 1, 0,  16'hFFFF, 0, 1);
        // BCD borrow ripple down
        vec(0, 1, 0, 1, 0, 16'h1000,  16'h1000, 0, 0,  16'h1000, 0, 0);
        vec(0, 0, 1, 1, 0, 16'h0000,  16'h0999, 0, 0,  16'h0999, 0, 0);
        // above-max digit in BCD down: becomes 9 without borrow
        vec(0, 1, 0, 0, 0, 16'h00A0,  16'h00A0, 0, 0,  16'h00A0, 0, 0);
        vec(0, 0, 1, 1, 0, 16'h0000,  16'h0099, 0, 0,  16'h0099, 0, 0);
        // at_limit follows mode/direction with en low
        vec(0, 1, 0, 1, 1, 16'h9999,  16'h9999, 0, 1,  16'h9999, 0, 1);
        vec(0, 0, 0, 0, 1, 16'h0000,  16'h9999, 0, 0,  16'h9999, 0, 0);
        vec(0, 0, 0, 1, 0, 16'h0000,  16'h9999, 0, 0,  16'h9999, 0, 0);
        vec(0, 0, 0, 1, 1, 16'h0000,  16'h9999, 0, 1,  16'h9999, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
